// File: rtl/anim_frame_sequencer.sv
// Sprite animation sequencer: steps through FRAME_COUNT ROM frames,
// handshaking draw/hold/erase with a downstream drawer.
module anim_frame_sequencer #(
  parameter int unsigned FRAME_COUNT = 4,
  parameter int unsigned FRAME_WORDS = 9600,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned ORIGIN_X    = 120,
  parameter int unsigned ORIGIN_Y    = 70
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        loop_en,
  output logic        draw_req,
  input  logic        draw_done,
  output logic        erase_req,
  input  logic        erase_done,
  output logic [8:0]  x_origin,
  output logic [7:0]  y_origin,
  output logic [15:0] rom_base,
  output logic [2:0]  frame_idx,
  output logic        busy,
  output logic        seq_done
);

  localparam logic [2:0]  LAST_FRAME = 3'(FRAME_COUNT - 1);
  localparam logic [15:0] FRAME_STEP = 16'(FRAME_WORDS);
  localparam logic [27:0] HOLD_LAST  = 28'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_HOLD,
    ST_ERASE,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  frame_idx_q, frame_idx_d;
  logic [15:0] rom_base_q, rom_base_d;
  logic [27:0] timer_q, timer_d;
  logic        draw_req_q, draw_req_d;
  logic        erase_req_q, erase_req_d;
  logic        seq_done_q, seq_done_d;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      frame_idx_q <= '0;
      rom_base_q  <= '0;
      timer_q     <= '0;
      draw_req_q  <= 1'b0;
      erase_req_q <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_idx_q <= frame_idx_d;
      rom_base_q  <= rom_base_d;
      timer_q     <= timer_d;
      draw_req_q  <= draw_req_d;
      erase_req_q <= erase_req_d;
      seq_done_q  <= seq_done_d;
    end
  end

  // Next state; the request flops are set on entry to DRAW/ERASE
  // and cleared on the edge that samples the matching done.
  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    rom_base_d  = rom_base_q;
    timer_d     = timer_q;
    draw_req_d  = draw_req_q;
    erase_req_d = erase_req_q;
    seq_done_d  = 1'b0;

    if (abort && state_q != ST_IDLE) begin
      // Abort beats any done arriving in the same cycle.
      state_d     = ST_IDLE;
      timer_d     = '0;
      draw_req_d  = 1'b0;
      erase_req_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_DRAW;
            frame_idx_d = '0;
            rom_base_d  = '0;
            draw_req_d  = 1'b1;
          end
        end
        ST_DRAW: begin
          if (draw_done && draw_req_q) begin
            state_d    = ST_HOLD;
            timer_d    = '0;
            draw_req_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_d     = ST_ERASE;
            timer_d     = '0;
            erase_req_d = 1'b1;
          end else begin
            timer_d = timer_q + 28'd1;
          end
        end
        ST_ERASE: begin
          if (erase_done && erase_req_q) begin
            state_d     = ST_NEXT;
            erase_req_d = 1'b0;
          end
        end
        ST_NEXT: begin
          if (frame_idx_q < LAST_FRAME) begin
            state_d     = ST_DRAW;
            frame_idx_d = frame_idx_q + 3'd1;
            rom_base_d  = rom_base_q + FRAME_STEP;
            draw_req_d  = 1'b1;
          end else if (loop_en) begin
            state_d     = ST_DRAW;
            frame_idx_d = '0;
            rom_base_d  = '0;
            draw_req_d  = 1'b1;
          end else begin
            state_d    = ST_DONE;
            seq_done_d = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d     = ST_IDLE;
          draw_req_d  = 1'b0;
          erase_req_d = 1'b0;
          timer_d     = '0;
        end
      endcase
    end
  end

  assign draw_req  = draw_req_q;
  assign erase_req = erase_req_q;
  assign seq_done  = seq_done_q;
  assign frame_idx = frame_idx_q;
  assign rom_base  = rom_base_q;
  assign busy      = (state_q != ST_IDLE);
  assign x_origin  = 9'(ORIGIN_X);
  assign y_origin  = 8'(ORIGIN_Y);

endmodule
